// File: rtl/axi4_master_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axi4_master_pkg
// Description : Shared types and constants for the AXI4 burst write master:
//               FSM state encoding, AXI field encodings and a helper that
//               turns a data-bus width into the AxSIZE encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] BURST_INCR                  = 2'b01;
    localparam logic [1:0] RESP_OKAY                   = 2'b00;
    localparam logic [3:0] CACHE_BUFFERABLE_MODIFIABLE = 4'b0011;

    // AxSIZE is log2 of the number of bytes carried by one beat.
    function automatic int axi_size(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage : axi4_master_pkg
`default_nettype wire

// File: rtl/axi4_burst_write_master.sv
`default_nettype none
// ============================================================================
// Module      : axi4_burst_write_master
// Description : Turns one command (start address, beats-1) plus a valid/ready
//               data stream into a single AXI4 INCR write burst and reports
//               completion (DONE) and failure (ERROR) per burst.
//               Optional macro AXI4_4K_CHECK_EN: reject commands whose burst
//               would cross a 4 KB boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_burst_write_master
    import axi4_master_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0,
    parameter int MAX_LEN    = 256
) (
    input  logic                      M_AXI_ACLK,
    input  logic                      M_AXI_ARESETN,
    input  logic                      CMD_VALID,
    output logic                      CMD_READY,
    input  logic [ADDR_WIDTH-1:0]     CMD_ADDR,
    input  logic [7:0]                CMD_LEN,
    input  logic [DATA_WIDTH-1:0]     S_TDATA,
    input  logic                      S_TVALID,
    output logic                      S_TREADY,
    output logic                      DONE,
    output logic                      ERROR,
    output logic                      BUSY,
    output logic [ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                M_AXI_AWLEN,
    output logic [2:0]                M_AXI_AWSIZE,
    output logic [1:0]                M_AXI_AWBURST,
    output logic                      M_AXI_AWLOCK,
    output logic [3:0]                M_AXI_AWCACHE,
    output logic [2:0]                M_AXI_AWPROT,
    output logic [3:0]                M_AXI_AWQOS,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WLAST,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [ID_WIDTH-1:0]       M_AXI_BID,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY
);

    localparam int                    c_size      = axi_size(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] c_addr_mask = ~ADDR_WIDTH'((1 << c_size) - 1);
    localparam logic [8:0]            c_max_len   = 9'(MAX_LEN);
    localparam logic [ID_WIDTH-1:0]   c_axi_id    = ID_WIDTH'(AXI_ID);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]              r_len;
    logic [7:0]              r_beat_cnt;
    logic                    r_done;
    logic                    r_error;
    logic                    r_cmd_ready;

    logic                    w_cmd_hs;
    logic                    w_w_hs;
    logic                    w_len_err;
    logic                    w_4k_err;
    logic                    w_reject;
    logic                    w_done_nxt;
    logic                    w_error_nxt;

    assign w_cmd_hs  = r_cmd_ready && CMD_VALID;
    assign w_w_hs    = (r_state == DATA) && S_TVALID && M_AXI_WREADY;
    // LEN+1 > MAX_LEN rewritten as LEN >= MAX_LEN to stay within 9 bits.
    assign w_len_err = ({1'b0, CMD_LEN} >= c_max_len);

`ifdef AXI4_4K_CHECK_EN
    localparam int c_bytes_per_beat = DATA_WIDTH / 8;
    logic [16:0] w_burst_end;
    // 17 bits hold the worst case: 4095 + 256 beats * 128 bytes.
    assign w_burst_end = {5'd0, CMD_ADDR[11:0]}
                       + (({9'd0, CMD_LEN} + 17'd1) * 17'(c_bytes_per_beat));
    assign w_4k_err    = (w_burst_end > 17'd4096);
`else
    assign w_4k_err    = 1'b0;
`endif

    assign w_reject = w_len_err || w_4k_err;

    // State register; reset abandons any burst in flight.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the completion/error pulse requests.
    always_comb begin
        w_next_state = r_state;
        w_done_nxt   = 1'b0;
        w_error_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cmd_hs) begin
                    if (w_reject) begin
                        w_done_nxt  = 1'b1;
                        w_error_nxt = 1'b1;
                    end else begin
                        w_next_state = ADDR;
                    end
                end
            end
            ADDR: begin
                if (M_AXI_AWREADY) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                if (w_w_hs && (r_beat_cnt == r_len)) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (M_AXI_BVALID) begin
                    w_next_state = IDLE;
                    w_done_nxt   = 1'b1;
                    w_error_nxt  = (M_AXI_BRESP != RESP_OKAY) || (M_AXI_BID != c_axi_id);
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Command latch, beat counter and registered status; CMD_READY stays low
    // during the DONE cycle so the next command is taken only afterwards.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_beat_cnt  <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
            r_cmd_ready <= (w_next_state == IDLE) && !w_done_nxt;
            if (w_cmd_hs) begin
                r_addr     <= CMD_ADDR;
                r_len      <= CMD_LEN;
                r_beat_cnt <= '0;
            end else if (w_w_hs) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
        end
    end

    assign CMD_READY     = r_cmd_ready;
    assign DONE          = r_done;
    assign ERROR         = r_error;
    assign BUSY          = (r_state != IDLE);

    assign M_AXI_AWID    = c_axi_id;
    assign M_AXI_AWADDR  = r_addr & c_addr_mask;
    assign M_AXI_AWLEN   = r_len;
    assign M_AXI_AWSIZE  = 3'(c_size);
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = CACHE_BUFFERABLE_MODIFIABLE;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;
    assign M_AXI_AWVALID = (r_state == ADDR);

    // W channel is a straight pass-through of the stream while in DATA.
    assign M_AXI_WDATA   = S_TDATA;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = (r_state == DATA) && S_TVALID;
    assign S_TREADY      = (r_state == DATA) && M_AXI_WREADY;
    assign M_AXI_WLAST   = (r_state == DATA) && (r_beat_cnt == r_len);

    assign M_AXI_BREADY  = (r_state == RESP);

endmodule : axi4_burst_write_master
`default_nettype wire

// File: tb/tb_axi4_burst_write_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_burst_write_master
// Description : Directed self-checking bench for axi4_burst_write_master with
//               a small in-line AXI slave model. Expectations for the 4 KB
//               case follow the AXI4_4K_CHECK_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_burst_write_master;

    localparam int DW = 256;
    localparam int AW = 32;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            CMD_VALID = 1'b0, CMD_READY;
    logic [AW-1:0]   CMD_ADDR = '0;
    logic [7:0]      CMD_LEN = '0;
    logic [DW-1:0]   S_TDATA = '0;
    logic            S_TVALID = 1'b0, S_TREADY;
    logic            DONE, ERROR, BUSY;
    logic [IW-1:0]   AWID;
    logic [AW-1:0]   AWADDR;
    logic [7:0]      AWLEN;
    logic [2:0]      AWSIZE, AWPROT;
    logic [1:0]      AWBURST;
    logic            AWLOCK, AWVALID;
    logic [3:0]      AWCACHE, AWQOS;
    logic            AWREADY = 1'b0;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WLAST, WVALID;
    logic            WREADY = 1'b0;
    logic [IW-1:0]   BID = '0;
    logic [1:0]      BRESP = '0;
    logic            BVALID = 1'b0, BREADY;

    always #5 clk = ~clk;

    axi4_burst_write_master #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .ID_WIDTH (IW), .AXI_ID (0), .MAX_LEN (256)
    ) u_dut (
        .M_AXI_ACLK (clk), .M_AXI_ARESETN (rst_n),
        .CMD_VALID (CMD_VALID), .CMD_READY (CMD_READY), .CMD_ADDR (CMD_ADDR), .CMD_LEN (CMD_LEN),
        .S_TDATA (S_TDATA), .S_TVALID (S_TVALID), .S_TREADY (S_TREADY),
        .DONE (DONE), .ERROR (ERROR), .BUSY (BUSY),
        .M_AXI_AWID (AWID), .M_AXI_AWADDR (AWADDR), .M_AXI_AWLEN (AWLEN), .M_AXI_AWSIZE (AWSIZE),
        .M_AXI_AWBURST (AWBURST), .M_AXI_AWLOCK (AWLOCK), .M_AXI_AWCACHE (AWCACHE),
        .M_AXI_AWPROT (AWPROT), .M_AXI_AWQOS (AWQOS), .M_AXI_AWVALID (AWVALID),
        .M_AXI_AWREADY (AWREADY),
        .M_AXI_WDATA (WDATA), .M_AXI_WSTRB (WSTRB), .M_AXI_WLAST (WLAST),
        .M_AXI_WVALID (WVALID), .M_AXI_WREADY (WREADY),
        .M_AXI_BID (BID), .M_AXI_BRESP (BRESP), .M_AXI_BVALID (BVALID), .M_AXI_BREADY (BREADY)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Command queue and per-burst observations of the slave model.
    logic [31:0] q_addr [2];
    logic [7:0]  q_len  [2];
    int          acc_cyc [2];
    int          done_cyc [2];
    logic        done_err [2];
    logic [31:0] seen_awaddr [2];
    logic [7:0]  seen_awlen [2];
    logic [2:0]  seen_awsize [2];
    int          beats [2];
    int          aw_cnt, done_cnt, data_bad, last_bad, err_nodone, bad_fields;
    bit          stall;
    logic [1:0]  s_bresp;
    logic [3:0]  s_bid;

    // Present n commands (CMD_VALID held high while any remain) and act as
    // the slave until n DONE pulses are seen or the cycle budget runs out.
    task automatic run(input int n, input int budget);
        int          next_cmd;
        int          wb;
        bit          b_pend;
        logic [31:0] exp32;
        aw_cnt = 0; done_cnt = 0; data_bad = 0; last_bad = 0; err_nodone = 0; bad_fields = 0;
        next_cmd = 0; b_pend = 1'b0;
        for (int i = 0; i < 2; i++) begin
            acc_cyc[i] = -1; done_cyc[i] = -1; done_err[i] = 1'b0;
            seen_awaddr[i] = '0; seen_awlen[i] = '0; seen_awsize[i] = '0; beats[i] = 0;
        end
        for (int cyc = 0; cyc < budget && done_cnt < n; cyc++) begin
            @(negedge clk);
            CMD_VALID = (next_cmd < n);
            if (next_cmd < n) begin
                CMD_ADDR = q_addr[next_cmd];
                CMD_LEN  = q_len[next_cmd];
            end
            AWREADY  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            WREADY   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            S_TVALID = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wb       = (aw_cnt > 0) ? ((aw_cnt - 1) % 2) : 0;
            exp32    = 32'hD000_0000 + 32'(wb << 8) + 32'(beats[wb]);
            S_TDATA  = {8{exp32}};
            BVALID   = b_pend && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
            BRESP    = s_bresp;
            BID      = s_bid;
            #1;
            if (CMD_VALID && CMD_READY) begin
                acc_cyc[next_cmd] = cyc;
                next_cmd++;
            end
            if (AWVALID && AWREADY) begin
                if (aw_cnt < 2) begin
                    seen_awaddr[aw_cnt] = AWADDR;
                    seen_awlen[aw_cnt]  = AWLEN;
                    seen_awsize[aw_cnt] = AWSIZE;
                end
                if (AWBURST !== 2'b01 || AWCACHE !== 4'b0011 || AWLOCK !== 1'b0 ||
                    AWPROT !== 3'b000 || AWQOS !== 4'b0000 || AWID !== 4'h0)
                    bad_fields++;
                aw_cnt++;
            end
            if (WVALID && WREADY) begin
                if (WDATA !== {8{exp32}}) data_bad++;
                if (WSTRB !== {(DW/8){1'b1}}) bad_fields++;
                if (WLAST !== (beats[wb] == int'(q_len[wb]))) last_bad++;
                if (WLAST) b_pend = 1'b1;
                beats[wb]++;
            end
            if (BVALID && BREADY) b_pend = 1'b0;
            if (ERROR && !DONE) err_nodone++;
            if (DONE) begin
                if (done_cnt < 2) begin
                    done_cyc[done_cnt] = cyc;
                    done_err[done_cnt] = ERROR;
                end
                done_cnt++;
            end
        end
        @(negedge clk);
        CMD_VALID = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; S_TVALID = 1'b0; BVALID = 1'b0;
        #1;
    endtask

    initial begin
        int hs;
        stall = 1'b0; s_bresp = 2'b00; s_bid = 4'h0;

        // Reset for 64 cycles; outputs must show the idle state.
        repeat (64) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", CMD_READY, 1);
        check("rst_awvalid",   AWVALID,   0);
        check("rst_busy",      BUSY,      0);
        check("rst_done",      DONE,      0);
        check("rst_bready",    BREADY,    0);
        rst_n = 1'b1;

        // Single beat, zero wait states.
        q_addr[0] = 32'hA000_1000; q_len[0] = 8'd0;
        run(1, 200);
        check("t1_done_cnt",  done_cnt, 1);
        check("t1_aw_cnt",    aw_cnt, 1);
        check("t1_awaddr",    seen_awaddr[0], 32'hA000_1000);
        check("t1_awlen",     seen_awlen[0], 0);
        check("t1_awsize",    seen_awsize[0], 5);
        check("t1_beats",     beats[0], 1);
        check("t1_data",      data_bad, 0);
        check("t1_wlast",     last_bad, 0);
        check("t1_fields",    bad_fields, 0);
        check("t1_error",     done_err[0], 0);
        check("t1_latency",   done_cyc[0] - acc_cyc[0], 4);

        // 16 beats with random stalls on AW, W and the stream.
        stall = 1'b1;
        q_addr[0] = 32'h1000_0040; q_len[0] = 8'd15;
        run(1, 3000);
        check("t2_done_cnt",  done_cnt, 1);
        check("t2_awlen",     seen_awlen[0], 15);
        check("t2_beats",     beats[0], 16);
        check("t2_data",      data_bad, 0);
        check("t2_wlast",     last_bad, 0);
        check("t2_error",     done_err[0], 0);
        stall = 1'b0;

        // SLVERR on a 4-beat burst.
        s_bresp = 2'b10;
        q_addr[0] = 32'h2000_0000; q_len[0] = 8'd3;
        run(1, 200);
        check("t3_done_cnt",  done_cnt, 1);
        check("t3_error",     done_err[0], 1);
        check("t3_err_alone", err_nodone, 0);
        check("t3_cmd_ready", CMD_READY, 1);
        check("t3_busy",      BUSY, 0);
        s_bresp = 2'b00;

        // Wrong BID with OKAY response is also a failed burst.
        s_bid = 4'h3;
        q_addr[0] = 32'h2000_1000; q_len[0] = 8'd0;
        run(1, 200);
        check("t3b_error",    done_err[0], 1);
        s_bid = 4'h0;

        // Reset during DATA after three of eight beats.
        @(negedge clk);
        CMD_VALID = 1'b1; CMD_ADDR = 32'h4000_0000; CMD_LEN = 8'd7;
        AWREADY = 1'b1; WREADY = 1'b1; S_TVALID = 1'b1;
        hs = 0;
        for (int c = 0; c < 50 && hs < 3; c++) begin
            @(negedge clk);
            CMD_VALID = 1'b0;
            #1;
            if (WVALID && WREADY) hs++;
        end
        check("t4_hs_reached", hs, 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_awvalid",   AWVALID, 0);
        check("t4_wvalid",    WVALID, 0);
        check("t4_tready",    S_TREADY, 0);
        check("t4_wlast",     WLAST, 0);
        check("t4_bready",    BREADY, 0);
        check("t4_busy",      BUSY, 0);
        check("t4_done",      DONE, 0);
        check("t4_cmd_ready", CMD_READY, 1);
        AWREADY = 1'b0; WREADY = 1'b0; S_TVALID = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t4_post_ready", CMD_READY, 1);
        check("t4_post_done",  DONE, 0);
        q_addr[0] = 32'h4000_0200; q_len[0] = 8'd1;
        run(1, 200);
        check("t4_rerun_done",  done_cnt, 1);
        check("t4_rerun_beats", beats[0], 2);
        check("t4_rerun_err",   done_err[0], 0);

        // Burst that crosses a 4 KB boundary: 0xFE0 + 4*32 = 0x1060.
        q_addr[0] = 32'h0000_0FE0; q_len[0] = 8'd3;
        run(1, 200);
        check("t5_done_cnt",  done_cnt, 1);
`ifdef AXI4_4K_CHECK_EN
        check("t5_aw_cnt",    aw_cnt, 0);
        check("t5_beats",     beats[0], 0);
        check("t5_error",     done_err[0], 1);
        check("t5_latency",   done_cyc[0] - acc_cyc[0], 1);
`else
        check("t5_aw_cnt",    aw_cnt, 1);
        check("t5_awaddr",    seen_awaddr[0], 32'h0000_0FE0);
        check("t5_beats",     beats[0], 4);
        check("t5_error",     done_err[0], 0);
`endif

        // Back-to-back commands with CMD_VALID held high.
        q_addr[0] = 32'h3000_0000; q_len[0] = 8'd0;
        q_addr[1] = 32'h3000_0104; q_len[1] = 8'd1;
        run(2, 300);
        check("t6_done_cnt",  done_cnt, 2);
        check("t6_accept2",   acc_cyc[1], done_cyc[0] + 1);
        check("t6_awaddr0",   seen_awaddr[0], 32'h3000_0000);
        check("t6_awaddr1",   seen_awaddr[1], 32'h3000_0100);
        check("t6_awlen1",    seen_awlen[1], 1);
        check("t6_beats1",    beats[1], 2);
        check("t6_data",      data_bad, 0);
        check("t6_wlast",     last_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_axi4_burst_write_master
`default_nettype wire
